// File: rtl/fifo_rd_arbiter_if.sv
// Shared FIFO read-port bus between the FIFO,
// the read arbiter and its consumers.
interface fifo_rd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic            Rempty;
  logic [DW-1:0]   Rdata;
  logic            Rinc;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] valid;
  logic [DW-1:0]   data_out;

  modport master (
    input  Rempty, Rdata, req, ready,
    output Rinc, gnt, valid, data_out
  );

  modport slave (
    output Rempty, Rdata, req, ready,
    input  Rinc, gnt, valid, data_out
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin sharing of one FWFT FIFO read port
// among NREQ consumers, with bounded bursts.
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_rd_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);
  localparam logic [PW-1:0] TOP  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   cand;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic [DW-1:0]   word;
  logic            out_valid;
  logic            hit;
  logic            own_req;
  logic            own_rdy;
  logic            pop;
  logic            done;

  assign own_req = bus.req[owner];
  assign own_rdy = bus.ready[owner];
  assign pop  = (state == XFER) && !bus.Rempty && own_req &&
                (!out_valid || own_rdy);
  assign done = !out_valid || own_rdy;

  assign bus.Rinc     = pop;
  assign bus.gnt      = grant;
  assign bus.valid    = grant & {NREQ{out_valid}};
  assign bus.data_out = word;

  // First asserted request scanning circularly from rr_ptr
  always_comb begin
    sel  = rr_ptr;
    cand = '0;
    hit  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NREQ);
      if (!hit && bus.req[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (|bus.req) state_nxt = XFER;
      XFER:
        if (!own_req || (pop && cnt == LAST))
          state_nxt = DRAIN;
      DRAIN:
        if (done) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant, burst count, output word and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      owner     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      word      <= '0;
      rr_ptr    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            grant <= NREQ'(1) << sel;
            owner <= sel;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (pop) begin
            word      <= bus.Rdata;
            out_valid <= 1'b1;
            cnt       <= cnt + 1'b1;
          end else if (out_valid && own_rdy) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (done) begin
            out_valid <= 1'b0;
            grant     <= '0;
            rr_ptr    <= (owner == TOP) ? '0 : owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed scoreboard bench for fifo_rd_arbiter
// with a behavioural FWFT FIFO model.
module tb_fifo_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.NREQ(4), .DW(16)) bus ();

  fifo_rd_arbiter #(
    .NREQ (4),
    .DW   (16),
    .BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          who;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fifo_q[$];
  int          pop_cyc[$];
  logic [3:0]  gseq[$];
  logic [3:0]  last_gnt = '0;
  logic        rinc_s;
  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  int          cyc   = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] want_v);
    tests++;
    assert (obs === want_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, want_v);
    end
  endtask

  task automatic refresh();
    bus.Rempty = (fifo_q.size() == 0);
    bus.Rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
  endtask

  task automatic put(logic [15:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic want(int who, logic [15:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: monitor at negedge, FIFO pop after posedge
  task automatic step();
    logic [3:0] hs;
    int         who;
    exp_t       e;
    @(negedge clk);
    rinc_s = bus.Rinc;
    if (bus.Rinc) begin
      pops++;
      pop_cyc.push_back(cyc);
    end
    hs = bus.valid & bus.ready;
    if (hs != 4'b0) begin
      who = -1;
      for (int k = 0; k < 4; k++)
        if (hs[k]) who = k;
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_who", who, e.who);
        chk("sb_data", bus.data_out, e.data);
      end
    end
    if (bus.gnt != last_gnt && bus.gnt != 4'b0)
      gseq.push_back(bus.gnt);
    last_gnt = bus.gnt;
    @(posedge clk);
    #1;
    cyc++;
    if (rinc_s && rst_n && fifo_q.size() != 0)
      void'(fifo_q.pop_front());
    refresh();
  endtask

  initial begin
    int n1;
    int n3;
    int d;

    // Reset state
    rst_n = 1'b0;
    bus.req = '0;
    bus.ready = '0;
    refresh();
    step();
    step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_rinc", bus.Rinc, 0);
    chk("rst_data", bus.data_out, 0);
    rst_n = 1'b1;

    // Single requester, FIFO runs dry mid-burst
    pops = 0;
    gseq.delete();
    put(16'hA001);
    put(16'hA002);
    put(16'hA003);
    want(0, 16'hA001);
    want(0, 16'hA002);
    want(0, 16'hA003);
    want(0, 16'hA004);
    bus.req = 4'b0001;
    bus.ready = 4'b1111;
    step();
    chk("A_gnt", bus.gnt, 4'b0001);
    chk("A_no_early_valid", bus.valid, 0);
    step();
    chk("A_first_valid", bus.valid, 4'b0001);
    chk("A_first_data", bus.data_out, 16'hA001);
    repeat (4) step();
    chk("A_pops", pops, 3);
    chk("A_hold_gnt", bus.gnt, 4'b0001);
    chk("A_valid_clr", bus.valid, 0);
    chk("A_data_hold", bus.data_out, 16'hA003);
    put(16'hA004);
    step();
    chk("A_pop4", pops, 4);
    bus.req = 4'b0000;
    step();
    chk("A_release", bus.gnt, 0);
    step();
    chk("A_sb_empty", exp_q.size(), 0);
    chk("A_rr", dut.rr_ptr, 1);
    chk("A_gseq_n", gseq.size(), 1);

    // Asynchronous reset in the middle of a burst
    pops = 0;
    put(16'hB001);
    put(16'hB002);
    bus.req = 4'b0010;
    bus.ready = 4'b0000;
    step();
    step();
    step();
    chk("R_valid_pre", bus.valid, 4'b0010);
    chk("R_data_pre", bus.data_out, 16'hB001);
    #2 rst_n = 1'b0;
    #1;
    chk("R_gnt", bus.gnt, 0);
    chk("R_valid", bus.valid, 0);
    chk("R_rinc", bus.Rinc, 0);
    chk("R_data", bus.data_out, 0);
    bus.req = 4'b1010;
    step();
    rst_n = 1'b1;
    step();
    chk("R_regrant", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    step();
    step();
    chk("R_pops", pops, 1);
    chk("R_sb_empty", exp_q.size(), 0);
    fifo_q.delete();
    refresh();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // Two requesters sharing ten words
    pops = 0;
    pop_cyc.delete();
    gseq.delete();
    for (int i = 0; i < 10; i++) begin
      put(16'(i));
      want((i >= 4 && i < 8) ? 1 : 0, 16'(i));
    end
    bus.req = 4'b0011;
    bus.ready = 4'b1111;
    repeat (22) step();
    chk("B_pops", pops, 10);
    n1 = 0;
    n3 = 0;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      d = pop_cyc[i] - pop_cyc[i-1];
      if (d == 1) n1++;
      if (d == 3) n3++;
    end
    chk("B_gap_stream", n1, 7);
    chk("B_gap_handover", n3, 2);
    chk("B_gseq_n", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("B_g0", gseq[0], 4'b0001);
      chk("B_g1", gseq[1], 4'b0010);
      chk("B_g2", gseq[2], 4'b0001);
    end
    bus.req = 4'b0000;
    step();
    step();
    chk("B_idle", bus.gnt, 0);
    chk("B_sb_empty", exp_q.size(), 0);

    // Backpressure from the owner only
    pops = 0;
    put(16'hC001);
    put(16'hC002);
    put(16'hC003);
    want(2, 16'hC001);
    want(2, 16'hC002);
    want(2, 16'hC003);
    bus.req = 4'b0100;
    bus.ready = 4'b1011;
    step();
    chk("C_gnt", bus.gnt, 4'b0100);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("C_stable", bus.data_out, 16'hC001);
    end
    chk("C_pops_bp", pops, 1);
    chk("C_valid_bp", bus.valid, 4'b0100);
    bus.ready = 4'b1111;
    repeat (3) step();
    chk("C_pops", pops, 3);
    bus.req = 4'b0000;
    step();
    step();
    chk("C_sb_empty", exp_q.size(), 0);
    chk("C_rr", dut.rr_ptr, 3);

    // Round-robin wrap from the top index
    gseq.delete();
    for (int i = 0; i < 6; i++) put(16'h0030 + 16'(i));
    for (int i = 0; i < 4; i++) want(3, 16'h0030 + 16'(i));
    want(0, 16'h0034);
    want(0, 16'h0035);
    bus.req = 4'b1001;
    repeat (6) step();
    chk("W_rr0", dut.rr_ptr, 0);
    repeat (4) step();
    bus.req = 4'b0000;
    step();
    step();
    chk("W_rr1", dut.rr_ptr, 1);
    chk("W_gseq_n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("W_g0", gseq[0], 4'b1000);
      chk("W_g1", gseq[1], 4'b0001);
    end
    chk("W_sb_empty", exp_q.size(), 0);

    // Owner drops req holding an unaccepted word
    pops = 0;
    put(16'hD001);
    put(16'hD002);
    put(16'hD003);
    put(16'hD004);
    want(1, 16'hD001);
    want(1, 16'hD002);
    bus.req = 4'b0010;
    bus.ready = 4'b1111;
    step();
    step();
    step();
    bus.ready = 4'b0000;
    bus.req = 4'b0000;
    repeat (3) step();
    chk("D_pops", pops, 2);
    chk("D_valid", bus.valid, 4'b0010);
    chk("D_data", bus.data_out, 16'hD002);
    chk("D_rinc", bus.Rinc, 0);
    bus.ready = 4'b1111;
    step();
    chk("D_gnt", bus.gnt, 0);
    chk("D_rr", dut.rr_ptr, 2);
    chk("D_fifo_left", fifo_q.size(), 2);
    chk("D_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin arbiter that shares the single read port of the 16-bit FIFO (Rempty/Rdata/Rinc) between up to NREQ downstream consumers. It sits between the FIFO read side and the consumers. It grants the port to one requester at a time, pops words with Rinc, and presents each popped word in a registered output stage with a valid/ready handshake. Grants are bounded by a burst limit so that no consumer can monopolise the FIFO while others are waiting.

## Interface

- NREQ, 4, number of requesters (legal range 2..8)
- DW, 16, data width; matches the FIFO word
- BURST, 4, maximum words popped per grant (legal range 1..255)
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- Rempty  input  1  FIFO empty flag; Rdata is valid whenever Rempty=0 (first-word-fall-through)
- Rdata  input  DW  FIFO head word
- Rinc  output  1  pop strobe; one word is removed per cycle with Rinc=1 (combinational)
- req  input  NREQ  per-consumer request; level, held while the consumer wants data
- ready  input  NREQ  per-consumer accept for the output word
- gnt  output  NREQ  one-hot registered grant; all zeros when idle
- valid  output  NREQ  per-consumer output valid; equals out_valid AND gnt
- data_out  output  DW  registered output word, shared by all consumers

## Operation

- Internal state:
  - FSM with states IDLE, XFER and DRAIN.
  - rr_ptr, width clog2(NREQ), round-robin pointer.
  - cnt, width clog2(BURST+1), count of words popped in the current grant.
  - out_valid, one bit.
  - owner index.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, gnt=0, out_valid=0, valid=0, data_out=0, rr_ptr=0, cnt=0.
  - Rinc=0, because Rinc can only be asserted in XFER.
  - Assertion mid-transfer discards the held word. No pop occurs while rst_n=0.
- IDLE:
  - If req≠0, select the first asserted req scanning circularly from rr_ptr upward.
  - Set gnt to that requester's one-hot and owner to its index, clear cnt, and move to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - pop = !Rempty AND req[owner] AND (!out_valid OR ready[owner]), and Rinc = pop.
  - On pop: data_out<=Rdata, out_valid<=1, cnt<=cnt+1.
  - On ready[owner] with out_valid and no pop: out_valid<=0.
  - If pop and cnt==BURST-1, go to DRAIN.
  - If req[owner]=0, go to DRAIN. No pop happens in that cycle.
  - If Rempty=1 with req[owner]=1, stay in XFER with no pop. The grant is held and cnt does not advance.
- DRAIN:
  - Rinc=0.
  - If !out_valid, or out_valid AND ready[owner]: clear out_valid and gnt, set rr_ptr<=owner+1 (mod NREQ), go to IDLE.
  - Otherwise hold data_out and valid stable.
- data_out holds its last value whenever out_valid=0; it is not cleared.
- A requester dropping req does not lose an already-popped word. The word stays presented until ready.
- ready from non-owners is ignored. req changes of non-owners affect only the next arbitration.

## Timing

- Grant latency:
  - req rising in IDLE gives gnt at the next edge.
  - The first Rinc can occur in the first XFER cycle.
  - data_out and valid appear one edge after the Rinc cycle.
- Steady-state throughput is 1 word/cycle when ready=1 and Rempty=0.
- Hand-over costs:
  - DRAIN lasts at least 1 cycle.
  - IDLE lasts exactly 1 cycle when req≠0.
  - The minimum bubble between the last word of one owner and the first Rinc of the next is 2 cycles.
- Rinc depends combinationally on Rempty, req and ready; it is never asserted in IDLE or DRAIN.
- rr_ptr updates only on DRAIN exit, so a lone requester is re-granted after each burst.

## Test plan

- Reset mid-burst: pull rst_n low asynchronously while in XFER with out_valid=1 -> gnt, valid and Rinc go 0 immediately; data_out=0; the first grant after release goes to the lowest asserted req at or above index 0.
- Single requester, FIFO holds 0xA001..0xA003, ready=1, BURST=4 -> Rinc high for 3 cycles; data_out shows 0xA001..0xA003, each one cycle after its pop; with Rempty=1 the grant is held; a 4th word 0xA004 arriving is then popped, the arbiter enters DRAIN and returns to IDLE.
- req0 and req1 high, FIFO holds words 0..9, BURST=4, ready=1 -> consumer 0 receives 0..3, consumer 1 receives 4..7, consumer 0 receives 8..9; at least a 2-cycle Rinc gap at each hand-over.
- Backpressure: owner ready=0 after the first word -> exactly one pop; Rinc stays 0; data_out and valid are stable until ready=1; then popping resumes with no word lost or duplicated.
- Owner drops req after 2 of BURST=4 words while holding an unaccepted word -> no further Rinc; the word stays presented until ready; the arbiter then goes to IDLE and rr_ptr advances past the owner.
- Wrap-around: rr_ptr=3 (NREQ=4), req0 and req3 high -> consumer 3 is granted first, then consumer 0; rr_ptr becomes 0 and then 1.
